// File: rtl/sensor_frame_sender.sv
// sensor_frame_sender
//   Takes a snapshot of NUM_CH sensor channels and sends it to the UART driver
//   as one framed byte stream:
//     HEADER, Seq, mask byte, masked channel data (MSB first), checksum.
//   A frame starts either from a free-running PERIOD timer (Mode=0) or from
//   Send_Req (Mode=1). A trigger that arrives while a frame is in flight is
//   dropped, and Overrun pulses for one cycle.
//
// Ports
//   clk_100MHz   system clock
//   Rst          asynchronous reset, active low
//   Enable       1 = accept triggers
//   Mode         0 = periodic, 1 = on Send_Req
//   Send_Req     one-cycle frame request (Mode=1)
//   Ch_Mask      bit i includes channel i
//   Ch_Data      channel i at [i*DATA_W +: DATA_W]
//   Tx_ACK       UART byte acknowledge (pulse or level)
//   Tx_En        byte valid to UART
//   Send_Buffer  byte to UART, held between bytes
//   Busy         frame in progress (LOAD..WAIT_REL)
//   Frame_Done   one-cycle pulse after the checksum byte has been acknowledged
//   Overrun      one-cycle pulse, registered, when a trigger is dropped
//   Seq          sequence number of the next frame
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a trigger
// S_LOAD   | snapshot channels and mask, clear checksum and indices
// S_SEND   | Tx_En high, waiting for Tx_ACK
// S_WAIT_REL | Tx_En low, waiting for Tx_ACK to be released
// S_DONE   | Frame_Done pulse, Seq advances

module sensor_frame_sender #(
    parameter int         NUM_CH = 7,
    parameter int         DATA_W = 16,
    parameter logic [7:0] HEADER = 8'h55,
    parameter int         PERIOD = 1000000
) (
    input  logic                     clk_100MHz,
    input  logic                     Rst,
    input  logic                     Enable,
    input  logic                     Mode,
    input  logic                     Send_Req,
    input  logic [NUM_CH-1:0]        Ch_Mask,
    input  logic [NUM_CH*DATA_W-1:0] Ch_Data,
    input  logic                     Tx_ACK,
    output logic                     Tx_En,
    output logic [7:0]               Send_Buffer,
    output logic                     Busy,
    output logic                     Frame_Done,
    output logic                     Overrun,
    output logic [7:0]               Seq
);

    localparam int B     = DATA_W / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BS_W  = (B > 1) ? $clog2(B) : 1;
    localparam int TMR_W = $clog2(PERIOD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
    localparam logic [BS_W-1:0]  BS_LAST  = BS_W'(B - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_REL, S_DONE
    } state_t;

    // Position within the frame; PH_END marks "checksum already sent".
    typedef enum logic [2:0] {
        PH_HDR, PH_SEQ, PH_MASK, PH_DATA, PH_CHK, PH_END
    } phase_t;

    state_t                     state_q, state_d;
    phase_t                     phase_q, phase_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [7:0]                 seq_q, seq_d;
    logic [7:0]                 chk_q, chk_d;
    logic [7:0]                 send_buf_q, send_buf_d;
    logic                       overrun_q, overrun_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [BS_W-1:0]            bsel_q, bsel_d;
    logic [NUM_CH-1:0]          snap_mask_q, snap_mask_d;
    logic [NUM_CH*DATA_W-1:0]   snap_data_q, snap_data_d;

    logic                       trig_periodic;
    logic                       trigger;
    logic                       nxt_found;
    logic [CH_W-1:0]            nxt_ch;
    logic [7:0]                 mask_byte;
    logic [7:0]                 data_byte;
    logic [7:0]                 cur_byte;

    // Trigger generation; the timer runs regardless of Busy.
    always_comb begin
        timer_d       = timer_q;
        trig_periodic = 1'b0;
        if (Mode || !Enable) begin
            timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
            timer_d       = '0;
            trig_periodic = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end
        trigger = Mode ? (Send_Req & Enable) : trig_periodic;
    end

    // Lowest enabled channel after the current one (any channel while the
    // mask byte is being sent). Descending scan so the lowest index wins.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (snap_mask_q[i] && ((phase_q == PH_MASK) || (i > int'(ch_q)))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
        end
    end

    always_comb begin
        mask_byte               = '0;
        mask_byte[NUM_CH-1:0]   = snap_mask_q;
        data_byte               = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int b = 0; b < B; b++) begin
                if ((int'(ch_q) == i) && (int'(bsel_q) == b)) begin
                    data_byte = snap_data_q[i*DATA_W + (B-1-b)*8 +: 8];
                end
            end
        end
        case (phase_q)
            PH_HDR:  cur_byte = HEADER;
            PH_SEQ:  cur_byte = seq_q;
            PH_MASK: cur_byte = mask_byte;
            PH_DATA: cur_byte = data_byte;
            PH_CHK:  cur_byte = chk_q;
            default: cur_byte = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        seq_d       = seq_q;
        chk_d       = chk_q;
        send_buf_d  = send_buf_q;
        ch_d        = ch_q;
        bsel_d      = bsel_q;
        snap_mask_d = snap_mask_q;
        snap_data_d = snap_data_q;
        overrun_d   = trigger && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (trigger) state_d = S_LOAD;
            end
            S_LOAD: begin
                snap_data_d = Ch_Data;
                snap_mask_d = Ch_Mask;
                phase_d     = PH_HDR;
                ch_d        = '0;
                bsel_d      = '0;
                chk_d       = '0;
                send_buf_d  = HEADER;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (Tx_ACK) begin
                    state_d = S_WAIT_REL;
                    if (phase_q inside {PH_SEQ, PH_MASK, PH_DATA}) begin
                        chk_d = chk_q + cur_byte;
                    end
                    case (phase_q)
                        PH_HDR: phase_d = PH_SEQ;
                        PH_SEQ: phase_d = PH_MASK;
                        PH_MASK: begin
                            if (nxt_found) begin
                                phase_d = PH_DATA;
                                ch_d    = nxt_ch;
                                bsel_d  = '0;
                            end else begin
                                phase_d = PH_CHK;
                            end
                        end
                        PH_DATA: begin
                            if (bsel_q != BS_LAST) begin
                                bsel_d = bsel_q + 1'b1;
                            end else if (nxt_found) begin
                                ch_d   = nxt_ch;
                                bsel_d = '0;
                            end else begin
                                phase_d = PH_CHK;
                            end
                        end
                        default: phase_d = PH_END;
                    endcase
                end
            end
            S_WAIT_REL: begin
                if (!Tx_ACK) begin
                    if (phase_q == PH_END) begin
                        state_d = S_DONE;
                    end else begin
                        send_buf_d = cur_byte;
                        state_d    = S_SEND;
                    end
                end
            end
            S_DONE: begin
                seq_d   = seq_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_HDR;
            timer_q     <= '0;
            seq_q       <= '0;
            chk_q       <= '0;
            send_buf_q  <= '0;
            overrun_q   <= 1'b0;
            ch_q        <= '0;
            bsel_q      <= '0;
            snap_mask_q <= '0;
            snap_data_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            send_buf_q  <= send_buf_d;
            overrun_q   <= overrun_d;
            ch_q        <= ch_d;
            bsel_q      <= bsel_d;
            snap_mask_q <= snap_mask_d;
            snap_data_q <= snap_data_d;
        end
    end

    // Decoded from the state register so that reset clears Tx_En immediately.
    assign Tx_En       = (state_q == S_SEND);
    assign Busy        = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_WAIT_REL);
    assign Frame_Done  = (state_q == S_DONE);
    assign Overrun     = overrun_q;
    assign Send_Buffer = send_buf_q;
    assign Seq         = seq_q;

endmodule

// File: tb/tb_sensor_frame_sender.sv
module tb_sensor_frame_sender;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int PERIOD = 50;

    logic        clk_100MHz = 1'b0;
    logic        Rst        = 1'b0;
    logic        Enable     = 1'b0;
    logic        Mode       = 1'b1;
    logic        Send_Req   = 1'b0;
    logic [1:0]  Ch_Mask    = '0;
    logic [31:0] Ch_Data    = '0;
    logic        Tx_ACK     = 1'b0;
    logic        Tx_En;
    logic [7:0]  Send_Buffer;
    logic        Busy;
    logic        Frame_Done;
    logic        Overrun;
    logic [7:0]  Seq;

    sensor_frame_sender #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .HEADER(8'h55), .PERIOD(PERIOD)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .Rst        (Rst),
        .Enable     (Enable),
        .Mode       (Mode),
        .Send_Req   (Send_Req),
        .Ch_Mask    (Ch_Mask),
        .Ch_Data    (Ch_Data),
        .Tx_ACK     (Tx_ACK),
        .Tx_En      (Tx_En),
        .Send_Buffer(Send_Buffer),
        .Busy       (Busy),
        .Frame_Done (Frame_Done),
        .Overrun    (Overrun),
        .Seq        (Seq)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         fd_times[$];
    int         fd_cnt   = 0;
    int         ov_cnt   = 0;
    int         cyc      = 0;
    int         stab_err = 0;
    int         ack_delay = 3;
    int         ack_len   = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_hex(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic pulse_req();
        Send_Req = 1'b1;
        tick(1);
        Send_Req = 1'b0;
    endtask

    task automatic wait_fd(input string name, input int target, input int budget);
        int n = 0;
        while (fd_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, fd_cnt, target);
    endtask

    task automatic do_reset();
        @(posedge clk_100MHz);
        #4 Rst = 1'b0;
        @(posedge clk_100MHz);
        #4 Rst = 1'b1;
        tick(2);
    endtask

    // UART model and scoreboard monitor: acknowledges each byte after
    // ack_delay sampled cycles, holds ACK for ack_len cycles, and checks
    // every newly presented byte against the head of exp_q.
    logic       m_en, m_ack, in_byte = 1'b0, ack_issued = 1'b0;
    logic [7:0] cur_byte;
    int         cnt = 0, ack_left = 0;

    initial begin
        forever begin
            @(posedge clk_100MHz);
            #1;
            cyc++;
            m_en  = Tx_En;
            m_ack = Tx_ACK;
            if (Frame_Done) begin
                fd_cnt++;
                fd_times.push_back(cyc);
            end
            if (Overrun) ov_cnt++;
            if (Tx_ACK && ack_left > 0) begin
                ack_left--;
                if (ack_left == 0) Tx_ACK = 1'b0;
            end
            if (m_en) begin
                if (!in_byte) begin
                    in_byte    = 1'b1;
                    ack_issued = 1'b0;
                    cnt        = 0;
                    cur_byte   = Send_Buffer;
                    chk("tx_en_after_ack_release", m_ack, 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got %02h expected no byte", Send_Buffer);
                    end else begin
                        chk("frame_byte", Send_Buffer, exp_q.pop_front());
                    end
                end else if (Send_Buffer !== cur_byte) begin
                    stab_err++;
                end
                if (!ack_issued) begin
                    if (cnt == ack_delay) begin
                        Tx_ACK     = 1'b1;
                        ack_left   = ack_len;
                        ack_issued = 1'b1;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                in_byte = 1'b0;
            end
        end
    end

    initial begin
        int ov_base, fd_base, t_base, n;

        // Reset values
        tick(3);
        chk("rst_tx_en", Tx_En, 0);
        chk("rst_send_buffer", Send_Buffer, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_frame_done", Frame_Done, 0);
        chk("rst_overrun", Overrun, 0);
        chk("rst_seq", Seq, 0);
        @(posedge clk_100MHz);
        #4 Rst = 1'b1;
        tick(2);

        // Two channels, 3-cycle pulse ACK
        Enable  = 1'b1;
        Mode    = 1'b1;
        Ch_Mask = 2'b11;
        Ch_Data = {16'hABCD, 16'h1234};
        push_hex(64'h55000312_34ABCDC1, 8);
        pulse_req();
        wait_fd("frame_a_done", 1, 300);
        tick(1);
        chk("frame_a_seq", Seq, 1);
        chk("frame_a_busy_clear", Busy, 0);

        // Channel 1 only, then empty mask
        do_reset();
        chk("seq_after_reset", Seq, 0);
        Ch_Mask = 2'b10;
        Ch_Data = {16'h00FF, 16'h1234};
        push_hex(64'h55000200_FF01, 6);
        pulse_req();
        wait_fd("frame_b_done", 2, 300);
        tick(1);
        Ch_Mask = 2'b00;
        push_hex(64'h55010001, 4);
        pulse_req();
        wait_fd("frame_c_done", 3, 300);
        tick(1);
        chk("frame_c_seq", Seq, 2);

        // Level ACK held for 5 cycles per byte
        ack_delay = 1;
        ack_len   = 5;
        Ch_Mask   = 2'b01;
        Ch_Data   = {16'h0000, 16'hBEEF};
        push_hex(64'h550201BE_EFB0, 6);
        pulse_req();
        wait_fd("frame_level_done", 4, 400);
        tick(1);
        chk("frame_level_seq", Seq, 3);

        // Inputs change after LOAD; request during frame is dropped
        ack_delay = 3;
        ack_len   = 1;
        Ch_Mask   = 2'b11;
        Ch_Data   = {16'hABCD, 16'h1234};
        push_hex(64'h55030312_34ABCDC4, 8);
        ov_base = ov_cnt;
        pulse_req();
        tick(1);
        Ch_Data = 32'hFFFF_0000;
        Ch_Mask = 2'b00;
        tick(10);
        chk("busy_mid_frame", Busy, 1);
        pulse_req();
        tick(2);
        chk("overrun_on_request", ov_cnt - ov_base, 1);
        wait_fd("frame_snap_done", 5, 300);
        tick(20);
        chk("no_queued_frame", fd_cnt, 5);
        chk("frame_snap_seq", Seq, 4);
        chk("idle_after_drop", Busy, 0);

        // Reset during data bytes
        Ch_Mask = 2'b11;
        Ch_Data = {16'hABCD, 16'h1234};
        push_hex(64'h55040312_34ABCDC5, 8);
        pulse_req();
        n = 0;
        while (exp_q.size() > 4 && n < 200) begin
            tick(1);
            n++;
        end
        chk("reached_data_bytes", (exp_q.size() <= 4), 1);
        @(posedge clk_100MHz);
        #4 Rst = 1'b0;
        #1;
        chk("async_tx_en_drop", Tx_En, 0);
        chk("async_seq_clear", Seq, 0);
        chk("async_busy_clear", Busy, 0);
        exp_q.delete();
        @(posedge clk_100MHz);
        #4 Rst = 1'b1;
        tick(3);
        push_hex(64'h55000312_34ABCDC1, 8);
        pulse_req();
        wait_fd("frame_after_reset_done", 6, 300);
        tick(1);
        chk("frame_after_reset_seq", Seq, 1);

        // Periodic mode, immediate ACK, empty mask
        ack_delay = 0;
        ack_len   = 1;
        Ch_Mask   = 2'b00;
        push_hex(64'h55010001, 4);
        push_hex(64'h55020002, 4);
        push_hex(64'h55030003, 4);
        t_base = fd_times.size();
        Mode   = 1'b0;
        wait_fd("periodic_done", 9, 400);
        Enable = 1'b0;
        if (fd_times.size() >= t_base + 3) begin
            chk("period_interval_1", fd_times[t_base+1] - fd_times[t_base], PERIOD);
            chk("period_interval_2", fd_times[t_base+2] - fd_times[t_base+1], PERIOD);
        end else begin
            chk("period_frames_seen", fd_times.size() - t_base, 3);
        end
        tick(120);
        chk("periodic_stops_when_disabled", fd_cnt, 9);
        chk("periodic_seq", Seq, 4);

        // Periodic mode with slow ACK: frames longer than PERIOD
        ack_delay = 5;
        Ch_Mask   = 2'b11;
        Ch_Data   = {16'hABCD, 16'h1234};
        push_hex(64'h55040312_34ABCDC5, 8);
        push_hex(64'h55050312_34ABCDC6, 8);
        ov_base = ov_cnt;
        fd_base = fd_cnt;
        Enable  = 1'b1;
        wait_fd("overrun_frames_done", fd_base + 2, 600);
        Enable = 1'b0;
        tick(60);
        chk("periodic_overrun_count", ov_cnt - ov_base, 2);
        chk("overrun_frame_count", fd_cnt - fd_base, 2);
        chk("overrun_seq", Seq, 6);

        chk("send_buffer_stable", stab_err, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
